// File: rtl/cpu_decode.sv
// Moxie instruction decode stage: splits each fetched instruction into form, opcode,
// register fields and immediate, tracks its PC, and registers the result for execute.
module cpu_decode #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] opcode_i,
    input  logic [31:0] operand_i,
    input  logic        valid_i,
    output logic        stall_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [1:0]  form_o,
    output logic [7:0]  op_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [31:0] imm_o,
    output logic        long_o,
    output logic        illegal_o
);

    // Form-1 opcodes that carry a trailing 32-bit operand word.
    function automatic logic is_long_op(input logic [7:0] op8);
        case (op8)
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d,
            8'h1f, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: is_long_op = 1'b1;
            default: is_long_op = 1'b0;
        endcase
    endfunction

    logic [31:0] pc_r;
    logic        accept_s;
    logic [1:0]  form_s;
    logic [7:0]  op_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [31:0] imm_s;
    logic        long_s;
    logic        illegal_s;
    logic [31:0] br_off_s;

    assign stall_o  = valid_o & stall_i;
    assign accept_s = valid_i & ~stall_o & ~flush_i;
    // Branch offset counts halfwords: sign-extend the 10-bit field and scale by two.
    assign br_off_s = {{21{opcode_i[9]}}, opcode_i[9:0], 1'b0};

    // Field extraction and immediate selection for the instruction at the FIFO head.
    always_comb begin
        form_s    = 2'd0;
        op_s      = 8'd0;
        ra_s      = 4'd0;
        rb_s      = 4'd0;
        imm_s     = 32'd0;
        long_s    = 1'b0;
        illegal_s = 1'b0;
        case (opcode_i[15:14])
            2'b10: begin
                form_s = 2'd2;
                op_s   = {6'd0, opcode_i[13:12]};
                ra_s   = opcode_i[11:8];
                imm_s  = {24'd0, opcode_i[7:0]};
            end
            2'b11: begin
                form_s = 2'd3;
                op_s   = {4'd0, opcode_i[13:10]};
                imm_s  = pc_r + 32'd2 + br_off_s;
            end
            default: begin
                form_s    = 2'd0;
                op_s      = opcode_i[15:8];
                ra_s      = opcode_i[7:4];
                rb_s      = opcode_i[3:0];
                long_s    = is_long_op(opcode_i[15:8]);
                illegal_s = (opcode_i[15:8] == 8'h00) || (opcode_i[15:8] > 8'h39);
                if (long_s) begin
                    imm_s = operand_i;
                end else begin
                    imm_s = 32'd0;
                end
            end
        endcase
    end

    // PC tracking and output register; flush outranks everything but reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r      <= BOOT_ADDRESS;
            valid_o   <= 1'b0;
            pc_o      <= 32'd0;
            form_o    <= 2'd0;
            op_o      <= 8'd0;
            ra_o      <= 4'd0;
            rb_o      <= 4'd0;
            imm_o     <= 32'd0;
            long_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            pc_r    <= flush_pc_i;
            valid_o <= 1'b0;
        end else if (accept_s) begin
            pc_r      <= pc_r + (long_s ? 32'd6 : 32'd2);
            valid_o   <= 1'b1;
            pc_o      <= pc_r;
            form_o    <= form_s;
            op_o      <= op_s;
            ra_o      <= ra_s;
            rb_o      <= rb_s;
            imm_o     <= imm_s;
            long_o    <= long_s;
            illegal_o <= illegal_s;
        end else if (!stall_o) begin
            valid_o <= 1'b0;
        end
    end

endmodule
